// File: rtl/ether_tx_framer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ether_tx_framer
//
// RMII (2-bit, 50 MHz) Ethernet transmit framer. On a start request it emits
// preamble + SFD, the fixed MAC/EtherType header, the payload streamed in on
// axiid, optional zero padding, the CRC-32 FCS, then an enforced idle gap.
//
// Configuration macro:
//   ETHER_TX_PAD_EN  defined   -> payloads shorter than 46 bytes are zero-padded
//                                 up to 46 bytes before the FCS.
//                    undefined -> no padding; PAYLOAD goes straight to FCS.
//
// Ports:
//   clk          in   RMII reference clock, rising edge
//   rst          in   synchronous, active-high reset
//   start        in   single-cycle frame request (sampled in IDLE only)
//   payload_len  in   payload length in bytes, latched on accepted start
//   axiiv        in   payload dibit valid
//   axiid        in   payload dibit, LSB dibit of each byte first
//   data_request out  high in every PAYLOAD cycle (combinational)
//   axiov        out  registered TX_EN
//   axiod        out  registered TXD dibit
//   busy         out  high whenever not IDLE
//   done         out  one-cycle pulse on GAP -> IDLE
//   err          out  one-cycle pulse on payload underrun or rejected start
// -----------------------------------------------------------------------------
module ether_tx_framer #(
    parameter logic [47:0] DEST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE   = 16'h0800,
    parameter int          IFG_DIBITS  = 48,
    parameter int          MAX_PAYLOAD = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] payload_len,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        data_request,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PREAMBLE = 3'd1;
    localparam logic [2:0] HEADER   = 3'd2;
    localparam logic [2:0] PAYLOAD  = 3'd3;
    localparam logic [2:0] PAD      = 3'd4;
    localparam logic [2:0] FCS      = 3'd5;
    localparam logic [2:0] GAP      = 3'd6;

    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [12:0] IFG_LAST = 13'(IFG_DIBITS - 1);

    // Dibit number idx (0..55) of the 14-byte header, each byte sent LSB dibit first.
    function automatic logic [1:0] hdr_dibit(input logic [5:0] idx);
        logic [111:0] hdr;
        logic [6:0]   sh;
        hdr = {DEST_MAC, SRC_MAC, ETHERTYPE};
        sh  = 7'd104 - {idx[5:2], 3'b000} + {4'b0000, idx[1:0], 1'b0};
        return 2'(hdr >> sh);
    endfunction

    // Reflected CRC-32 (0x04C11DB7 -> 0xEDB88320) advanced by one dibit, bit 0 first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    logic [2:0]  state_r, state_n;
    logic [12:0] cnt_r, cnt_n;
    logic [12:0] len_dibits_r;
    logic [31:0] crc_r, crc_n;
    logic [31:0] fcs_s;
    logic        axiov_r, busy_r, done_r, err_r;
    logic [1:0]  axiod_r;
    logic        tx_valid_s, done_s, err_s, accept_s;
    logic [1:0]  tx_dibit_s;
    logic [2:0]  after_payload_s;

`ifdef ETHER_TX_PAD_EN
    logic [12:0] pad_dibits_r;
    logic [12:0] pad_dibits_s;

    // Number of zero-pad dibits needed to bring a short payload up to 46 bytes.
    always_comb begin
        if (payload_len < 11'd46) begin
            pad_dibits_s = {(11'd46 - payload_len), 2'b00};
        end else begin
            pad_dibits_s = 13'd0;
        end
    end

    assign after_payload_s = (pad_dibits_r != 13'd0) ? PAD : FCS;
`else
    assign after_payload_s = FCS;
`endif

    assign fcs_s        = ~crc_r;
    assign data_request = (state_r == PAYLOAD);
    assign axiov        = axiov_r;
    assign axiod        = axiod_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;

    // Next-state, per-cycle dibit selection and CRC update.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r + 13'd1;
        crc_n      = crc_r;
        tx_valid_s = 1'b0;
        tx_dibit_s = 2'b00;
        done_s     = 1'b0;
        err_s      = 1'b0;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_n = 13'd0;
                if (start) begin
                    if (payload_len > MAX_LEN) begin
                        err_s = 1'b1;
                    end else begin
                        accept_s = 1'b1;
                        state_n  = PREAMBLE;
                        crc_n    = 32'hFFFF_FFFF;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            PREAMBLE: begin
                tx_valid_s = 1'b1;
                // 31 dibits of 01, then the SFD's final 11 dibit.
                if (cnt_r == 13'd31) begin
                    tx_dibit_s = 2'b11;
                    state_n    = HEADER;
                    cnt_n      = 13'd0;
                end else begin
                    tx_dibit_s = 2'b01;
                end
            end
            HEADER: begin
                tx_valid_s = 1'b1;
                tx_dibit_s = hdr_dibit(cnt_r[5:0]);
                crc_n      = crc_dibit(crc_r, hdr_dibit(cnt_r[5:0]));
                if (cnt_r == 13'd55) begin
                    cnt_n   = 13'd0;
                    state_n = (len_dibits_r == 13'd0) ? after_payload_s : PAYLOAD;
                end else begin
                    state_n = HEADER;
                end
            end
            PAYLOAD: begin
                if (axiiv) begin
                    tx_valid_s = 1'b1;
                    tx_dibit_s = axiid;
                    crc_n      = crc_dibit(crc_r, axiid);
                    if (cnt_r == len_dibits_r - 13'd1) begin
                        cnt_n   = 13'd0;
                        state_n = after_payload_s;
                    end else begin
                        state_n = PAYLOAD;
                    end
                end else begin
                    // Underrun: abandon the frame, no FCS, straight to the gap.
                    err_s   = 1'b1;
                    cnt_n   = 13'd0;
                    state_n = GAP;
                end
            end
            PAD: begin
`ifdef ETHER_TX_PAD_EN
                tx_valid_s = 1'b1;
                tx_dibit_s = 2'b00;
                crc_n      = crc_dibit(crc_r, 2'b00);
                if (cnt_r == pad_dibits_r - 13'd1) begin
                    cnt_n   = 13'd0;
                    state_n = FCS;
                end else begin
                    state_n = PAD;
                end
`else
                cnt_n   = 13'd0;
                state_n = IDLE;
`endif
            end
            FCS: begin
                tx_valid_s = 1'b1;
                tx_dibit_s = 2'(fcs_s >> {cnt_r[3:0], 1'b0});
                if (cnt_r == 13'd15) begin
                    cnt_n   = 13'd0;
                    state_n = GAP;
                end else begin
                    state_n = FCS;
                end
            end
            GAP: begin
                if (cnt_r == IFG_LAST) begin
                    cnt_n   = 13'd0;
                    done_s  = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = GAP;
                end
            end
            default: begin
                cnt_n   = 13'd0;
                state_n = IDLE;
            end
        endcase
    end

    // State, counters, CRC and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 13'd0;
            len_dibits_r <= 13'd0;
            crc_r        <= 32'h0000_0000;
            axiov_r      <= 1'b0;
            axiod_r      <= 2'b00;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            crc_r   <= crc_n;
            axiov_r <= tx_valid_s;
            axiod_r <= tx_valid_s ? tx_dibit_s : 2'b00;
            busy_r  <= (state_n != IDLE);
            done_r  <= done_s;
            err_r   <= err_s;
            if (accept_s) begin
                len_dibits_r <= {payload_len, 2'b00};
            end else begin
                len_dibits_r <= len_dibits_r;
            end
        end
    end

`ifdef ETHER_TX_PAD_EN
    // Pad length is fixed when the frame is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_dibits_r <= 13'd0;
        end else if (accept_s) begin
            pad_dibits_r <= pad_dibits_s;
        end else begin
            pad_dibits_r <= pad_dibits_r;
        end
    end
`endif

endmodule

// File: tb/tb_ether_tx_framer.sv
`timescale 1ns/1ps
// Scoreboard bench for ether_tx_framer: each frame request pushes its expected
// dibit stream into exp_q; a negedge monitor pops and compares every axiov dibit.
module tb_ether_tx_framer;

    localparam int IFG = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] payload_len = 11'd0;
    logic        axiiv = 1'b0;
    logic [1:0]  axiid = 2'b00;
    logic        data_request, axiov, busy, done, err;
    logic [1:0]  axiod;

    ether_tx_framer dut (
        .clk(clk), .rst(rst), .start(start), .payload_len(payload_len),
        .axiiv(axiiv), .axiid(axiid), .data_request(data_request),
        .axiov(axiov), .axiod(axiod), .busy(busy), .done(done), .err(err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] exp_q[$];
    logic [1:0] exp_d;
    int vectors = 0;
    int miscompares = 0;
    int nov = 0, nerr = 0, ndr = 0, last_high = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every transmitted dibit against the scoreboard queue.
    always @(negedge clk) begin
        if (err) nerr++;
        if (data_request) ndr++;
        if (axiov) begin
            nov++;
            last_high = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_dibit", 1, 0);
            end else begin
                exp_d = exp_q.pop_front();
                chk("dibit", int'(axiod), int'(exp_d));
            end
        end else begin
            chk("idle_axiod", int'(axiod), 0);
        end
    end

    function automatic logic [7:0] pbyte(input int k);
        return 8'((k * 37 + 90) & 255);
    endfunction

    function automatic logic [1:0] pdibit(input int k);
        logic [7:0] b;
        b = pbyte(k / 4);
        return b[2 * (k % 4) +: 2];
    endfunction

    function automatic int pad_bytes(input int len);
`ifdef ETHER_TX_PAD_EN
        return (len < 46) ? 46 - len : 0;
`else
        return 0;
`endif
    endfunction

    // Reference CRC-32 (IEEE 802.3, reflected) over one byte.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int j = 0; j < 8; j++) begin
            if (c[0] ^ b[j]) c = (c >> 1) ^ 32'hEDB8_8320;
            else c = c >> 1;
        end
        return c;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int j = 0; j < 4; j++) exp_q.push_back(b[2 * j +: 2]);
    endtask

    // Build the expected dibit stream; drop_at >= 0 truncates after that many payload dibits.
    task automatic push_frame(input int len, input int drop_at);
        logic [7:0]  hdr [14];
        logic [31:0] crc;
        logic [31:0] fcs;
        hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00};
        for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 14; i++) begin
            push_byte(hdr[i]);
            crc = crc_byte(crc, hdr[i]);
        end
        if (drop_at >= 0) begin
            for (int k = 0; k < drop_at; k++) exp_q.push_back(pdibit(k));
        end else begin
            for (int k = 0; k < len; k++) begin
                push_byte(pbyte(k));
                crc = crc_byte(crc, pbyte(k));
            end
            for (int k = 0; k < pad_bytes(len); k++) begin
                push_byte(8'h00);
                crc = crc_byte(crc, 8'h00);
            end
            fcs = ~crc;
            for (int i = 0; i < 16; i++) exp_q.push_back(fcs[2 * i +: 2]);
        end
    endtask

    // Request a frame (caller is at a negedge), feed payload on demand, wait for done.
    task automatic run_frame(input int len, input int drop_at, input bit mid_start, input int rst_at);
        int idx;
        bit got_done;
        int pad;
        idx = 0;
        got_done = 1'b0;
        pad = pad_bytes(len);
        push_frame(len, drop_at);
        nov = 0; nerr = 0; ndr = 0;
        start = 1'b1;
        payload_len = 11'(len);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        for (int i = 1; i < 8000 && !got_done; i++) begin
            if (data_request) begin
                axiid = pdibit(idx);
                axiiv = (idx != drop_at);
                idx++;
            end else begin
                axiiv = 1'b0;
                axiid = 2'b00;
            end
            if (mid_start && i == 50) begin
                start = 1'b1;
                payload_len = 11'd3;
            end else begin
                start = 1'b0;
            end
            if (rst_at > 0 && i == rst_at) begin
                rst = 1'b1;
                axiiv = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_mid_axiov", int'(axiov), 0);
                chk("rst_mid_busy", int'(busy), 0);
                chk("rst_mid_req", int'(data_request), 0);
                exp_q.delete();
                return;
            end
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        axiiv = 1'b0;
        start = 1'b0;
        chk("done_seen", int'(got_done), 1);
        chk("tx_cycles", nov, (drop_at >= 0) ? 88 + drop_at : 88 + 4 * (len + pad) + 16);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
        chk("err_pulses", nerr, (drop_at >= 0) ? 1 : 0);
        chk("req_cycles", ndr, (drop_at >= 0) ? drop_at + 1 : 4 * len);
        chk("done_delay", cyc - last_high, (drop_at >= 0) ? IFG + 1 : IFG);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_axiov", int'(axiov), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_req", int'(data_request), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_axiov", int'(axiov), 0);

        run_frame(10, -1, 1'b1, 0);   // start pulsed mid-HEADER must be ignored
        run_frame(0, -1, 1'b0, 0);    // issued in the done cycle
        run_frame(46, -1, 1'b0, 0);

        @(negedge clk);
        start = 1'b1;
        payload_len = 11'd1501;
        @(negedge clk);
        start = 1'b0;
        chk("reject_err", int'(err), 1);
        chk("reject_busy", int'(busy), 0);
        @(negedge clk);
        chk("reject_err_clear", int'(err), 0);
        chk("reject_busy_idle", int'(busy), 0);

        run_frame(20, 10, 1'b0, 0);   // underrun at payload dibit 10
        @(negedge clk);
        run_frame(30, -1, 1'b0, 100); // reset mid-PAYLOAD
        @(negedge clk);
        run_frame(5, -1, 1'b0, 0);
        run_frame(1500, -1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
